// File: rtl/decade_counter.sv
// Modulo-MODULUS up-counter with synchronous clear and terminal-count flag.
// Out-of-range counts return to zero on the next edge.
module decade_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  // >= folds the wrap and the illegal-state recovery into one compare
  always_ff @(posedge clk) begin
    if (clr)
      count <= '0;
    else if (count >= LAST)
      count <= '0;
    else
      count <= count + WIDTH'(1);
  end

  assign tc = (count == LAST);

endmodule

// File: tb/tb_decade_counter.sv
// Scoreboard bench for decade_counter: a reference model pushes
// expected counts, which are popped after each rising edge.
module tb_decade_counter;

  logic       clk;
  logic       clr;
  logic [3:0] count;
  logic       tc;

  int checks;
  int failures;
  int m;
  int q[$];

  decade_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .clk   (clk),
    .clr   (clr),
    .count (count),
    .tc    (tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_edge(input logic c);
    int e;
    clr = c;
    if (c) e = 0;
    else if (m >= 9) e = 0;
    else e = m + 1;
    m = e;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int e;
    for (int i = 0; i < 2; i++) begin
      drive_edge(1'b1);
      e = q.pop_front();
      checks++;
      if (count !== 4'(e)) begin
        failures++;
        $display("FAIL reset_count got=%0d exp=%0d", count, e);
      end
      checks++;
      if (tc !== 1'b0) begin
        failures++;
        $display("FAIL reset_tc got=%b exp=0", tc);
      end
    end
  endtask

  task automatic test_free_run();
    int e;
    int tc_hits;
    tc_hits = 0;
    for (int i = 0; i < 25; i++) begin
      drive_edge(1'b0);
      e = q.pop_front();
      checks++;
      if (count !== 4'(e) || count > 4'd9) begin
        failures++;
        $display("FAIL free_run_count step=%0d got=%0d exp=%0d", i, count, e);
      end
      checks++;
      if (tc !== (e == 9)) begin
        failures++;
        $display("FAIL free_run_tc step=%0d got=%b exp=%b", i, tc, e == 9);
      end
      if (tc === 1'b1) tc_hits++;
    end
    checks++;
    if (tc_hits != 2) begin
      failures++;
      $display("FAIL free_run_tc_count got=%0d exp=2", tc_hits);
    end
  endtask

  task automatic test_wrap();
    int e;
    for (int i = 0; i < 12 && m != 9; i++) begin
      drive_edge(1'b0);
      void'(q.pop_front());
    end
    checks++;
    if (count !== 4'd9 || tc !== 1'b1) begin
      failures++;
      $display("FAIL wrap_at_nine got=%0d tc=%b exp=9 tc=1", count, tc);
    end
    for (int i = 0; i < 2; i++) begin
      drive_edge(1'b0);
      e = q.pop_front();
      checks++;
      if (count !== 4'(e) || tc !== 1'b0) begin
        failures++;
        $display("FAIL wrap_step%0d got=%0d tc=%b exp=%0d tc=0", i, count, tc, e);
      end
    end
  endtask

  task automatic test_mid_clear();
    int e;
    drive_edge(1'b1);
    void'(q.pop_front());
    for (int i = 0; i < 3; i++) begin
      drive_edge(1'b0);
      void'(q.pop_front());
    end
    checks++;
    if (count !== 4'd3) begin
      failures++;
      $display("FAIL mid_pre_count got=%0d exp=3", count);
    end
    for (int i = 0; i < 2; i++) begin
      drive_edge(1'b1);
      e = q.pop_front();
      checks++;
      if (count !== 4'(e)) begin
        failures++;
        $display("FAIL mid_clear_hold%0d got=%0d exp=%0d", i, count, e);
      end
    end
    for (int i = 0; i < 3; i++) begin
      drive_edge(1'b0);
      e = q.pop_front();
      checks++;
      if (count !== 4'(e)) begin
        failures++;
        $display("FAIL mid_resume%0d got=%0d exp=%0d", i, count, e);
      end
    end
  endtask

  task automatic test_clear_terminal();
    int e;
    for (int i = 0; i < 12 && m != 8; i++) begin
      drive_edge(1'b0);
      void'(q.pop_front());
    end
    drive_edge(1'b0);
    void'(q.pop_front());
    checks++;
    if (count !== 4'd9 || tc !== 1'b1) begin
      failures++;
      $display("FAIL term_pre got=%0d tc=%b exp=9 tc=1", count, tc);
    end
    drive_edge(1'b1);
    e = q.pop_front();
    checks++;
    if (count !== 4'(e) || tc !== 1'b0) begin
      failures++;
      $display("FAIL term_clear got=%0d tc=%b exp=%0d tc=0", count, tc, e);
    end
    drive_edge(1'b0);
    e = q.pop_front();
    checks++;
    if (count !== 4'(e)) begin
      failures++;
      $display("FAIL term_release got=%0d exp=%0d", count, e);
    end
  endtask

  task automatic test_illegal();
    int e;
    clr = 1'b0;
    force dut.count = 4'd12;
    #3;
    checks++;
    if (tc !== 1'b0) begin
      failures++;
      $display("FAIL illegal_tc got=%b exp=0", tc);
    end
    #4;
    release dut.count;
    m = 12;
    drive_edge(1'b0);
    e = q.pop_front();
    checks++;
    if (count !== 4'(e)) begin
      failures++;
      $display("FAIL illegal_recover got=%0d exp=%0d", count, e);
    end
    for (int i = 0; i < 3; i++) begin
      drive_edge(1'b0);
      e = q.pop_front();
      checks++;
      if (count !== 4'(e)) begin
        failures++;
        $display("FAIL illegal_seq%0d got=%0d exp=%0d", i, count, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    int e;
    logic pat [0:7];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++) begin
      drive_edge(pat[i]);
      e = q.pop_front();
      checks++;
      if (count !== 4'(e)) begin
        failures++;
        $display("FAIL pulse_step%0d got=%0d exp=%0d", i, count, e);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    m        = 0;
    clr      = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_free_run();
    test_wrap();
    test_mid_clear();
    test_clear_terminal();
    test_illegal();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
